// File: rtl/dmem_mmio_bus.sv
// Data-side bus slave: RAM, LEDs, UART TX with FIFO, and an optional cycle timer (enabled by DMEM_TIMER_EN).
// Latency: reads are combinational in the same cycle; writes and peripheral state update on the next clk edge.
// Backpressure: none toward the CPU; a TX byte written while the FIFO is full with no pop is dropped and sets sticky overflow.

// Generic synchronous FIFO with count; power-of-two depth.
// Latency: a push is visible at the head on the edge after it is written.
// Backpressure: in_rdy is low only when full and no pop occurs in the same cycle.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_vld,
    input  logic [W-1:0]               in_dat,
    output logic                       in_rdy,
    input  logic                       out_rdy,
    output logic                       out_vld,
    output logic [W-1:0]               out_dat,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign full    = (count == CW'(DEPTH));
    assign out_vld = (count != '0);
    assign out_dat = mem[rd_ptr];
    assign pop     = out_rdy && out_vld;
    assign in_rdy  = !full || pop;
    assign push    = in_vld && in_rdy;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end
endmodule

// Memory-mapped bus slave on the CPU MEM-stage data port.
// Latency: combinational read, registered writes, registered uart_tx.
// Backpressure: none toward the CPU; overflowing TX bytes are dropped and flagged.
module dmem_mmio_bus #(
    parameter int RAM_WORDS    = 1024,
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic        dmem_we,
    input  logic [3:0]  dmem_be,
    output logic [31:0] dmem_rdata,
    output logic [3:0]  leds,
    output logic        uart_tx
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int BW = $clog2(CLKS_PER_BIT + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;

    logic [31:0]   ram [RAM_WORDS];
    logic [AW-1:0] ram_idx;
    logic          ram_sel, led_sel, txd_sel, stat_sel;
    logic [31:0]   wlane;
    logic [31:0]   status;

    logic          fifo_in_rdy, fifo_out_vld, fifo_full, pop;
    logic [7:0]    fifo_head;
    logic [CW-1:0] fifo_count;
    logic          overflow;

    tx_state_t     state, state_n;
    logic [BW-1:0] baud_cnt, baud_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [7:0]    shreg, sh_n;
    logic          tx_n;

    assign ram_sel  = (dmem_addr[31:AW+2] == '0);
    assign ram_idx  = dmem_addr[AW+1:2];
    assign led_sel  = (dmem_addr == 32'hFFFF_FFF0);
    assign txd_sel  = (dmem_addr == 32'hFFFF_FFF4);
    assign stat_sel = (dmem_addr == 32'hFFFF_FFF8);

    // Byte and halfword stores arrive unshifted, so replicate them across lanes.
    always_comb begin
        wlane = dmem_wdata;
        unique case (dmem_be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: wlane = {4{dmem_wdata[7:0]}};
            4'b0011, 4'b1100:                   wlane = {2{dmem_wdata[15:0]}};
            default:                            wlane = dmem_wdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (dmem_we && ram_sel) begin
            for (int i = 0; i < 4; i++) begin
                if (dmem_be[i]) ram[ram_idx][8*i +: 8] <= wlane[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            leds     <= 4'h0;
            overflow <= 1'b0;
        end else begin
            if (dmem_we && led_sel) leds <= dmem_wdata[3:0];
            if (dmem_we && stat_sel)
                overflow <= 1'b0;
            else if (dmem_we && txd_sel && !fifo_in_rdy)
                overflow <= 1'b1;
        end
    end

    sync_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (dmem_we && txd_sel),
        .in_dat  (dmem_wdata[7:0]),
        .in_rdy  (fifo_in_rdy),
        .out_rdy (pop),
        .out_vld (fifo_out_vld),
        .out_dat (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full)
    );

`ifdef DMEM_TIMER_EN
    logic        tmr_sel;
    logic [31:0] timer;
    assign tmr_sel = (dmem_addr == 32'hFFFF_FFFC);

    always_ff @(posedge clk) begin
        if (rst)                      timer <= 32'h0;
        else if (dmem_we && tmr_sel)  timer <= 32'h0;
        else                          timer <= timer + 32'd1;
    end
`endif

    assign status = {16'b0, 8'(fifo_count), 4'b0, overflow, !fifo_out_vld, fifo_full,
                     state != S_IDLE};

    always_comb begin
        dmem_rdata = 32'h0;
        if (ram_sel)       dmem_rdata = ram[ram_idx];
        else if (led_sel)  dmem_rdata = {28'b0, leds};
        else if (stat_sel) dmem_rdata = status;
`ifdef DMEM_TIMER_EN
        else if (tmr_sel)  dmem_rdata = timer;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            uart_tx  <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            shreg    <= sh_n;
            uart_tx  <= tx_n;
        end
    end

    // uart_tx is registered, so each transition loads the level of the state being entered.
    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_cnt;
        sh_n    = shreg;
        tx_n    = uart_tx;
        pop     = 1'b0;
        unique case (state)
            S_IDLE: begin
                tx_n = 1'b1;
                if (fifo_out_vld) begin
                    pop     = 1'b1;
                    sh_n    = fifo_head;
                    bit_n   = 3'd0;
                    baud_n  = '0;
                    tx_n    = 1'b0;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_n  = '0;
                    tx_n    = shreg[0];
                    state_n = S_DATA;
                end else begin
                    baud_n = baud_cnt + BW'(1);
                end
            end
            S_DATA: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_n = '0;
                    if (bit_cnt == 3'd7) begin
                        tx_n    = 1'b1;
                        state_n = S_STOP;
                    end else begin
                        bit_n = bit_cnt + 3'd1;
                        sh_n  = {1'b0, shreg[7:1]};
                        tx_n  = shreg[1];
                    end
                end else begin
                    baud_n = baud_cnt + BW'(1);
                end
            end
            S_STOP: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_n  = '0;
                    state_n = S_IDLE;
                end else begin
                    baud_n = baud_cnt + BW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_dmem_mmio_bus.sv
// Directed bench for dmem_mmio_bus: RAM lanes, LEDs, unmapped space, UART framing/FIFO/overflow, reset, timer.
module tb_dmem_mmio_bus;
    localparam logic [31:0] A_LED  = 32'hFFFF_FFF0;
    localparam logic [31:0] A_TXD  = 32'hFFFF_FFF4;
    localparam logic [31:0] A_STAT = 32'hFFFF_FFF8;
    localparam logic [31:0] A_TMR  = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [3:0]  leds;
    logic        uart_tx;

    int   errors = 0;
    int   checks = 0;
    logic logging = 1'b0;
    logic txlog[$];

    dmem_mmio_bus #(.RAM_WORDS(1024), .CLKS_PER_BIT(4), .FIFO_DEPTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_we    (dmem_we),
        .dmem_be    (dmem_be),
        .dmem_rdata (dmem_rdata),
        .leds       (leds),
        .uart_tx    (uart_tx)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic cycle();
        @(posedge clk);
        #1;
        if (logging) txlog.push_back(uart_tx);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        dmem_addr  = a;
        dmem_wdata = d;
        dmem_be    = be;
        dmem_we    = 1'b1;
        cycle();
        dmem_we    = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        dmem_addr = a;
        #1;
        d = dmem_rdata;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    logic [31:0] rv, st;
    logic        txs [45];
    logic        bsy [45];
    logic [9:0]  frame_exp;
    logic [7:0]  byte_rx;
    int          nbusy, n, frames, i, prev_start;

    initial begin
        dmem_addr = 32'h0; dmem_wdata = 32'h0; dmem_we = 1'b0; dmem_be = 4'h0;
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;

        // Reset state
        chk("rst_uart_tx", {31'b0, uart_tx}, 32'h1);
        chk("rst_leds", {28'b0, leds}, 32'h0);
        rd(A_STAT, rv); chk("rst_status", rv, 32'h0000_0004);

        // RAM byte/halfword lanes
        wr(32'h4, 32'h1122_3344, 4'b1111);
        wr(32'h5, 32'h0000_00AB, 4'b0010);
        rd(32'h4, rv); chk("ram_sb", rv, 32'h1122_AB44);
        wr(32'h6, 32'h0000_BEEF, 4'b1100);
        rd(32'h4, rv); chk("ram_sh_hi", rv, 32'hBEEF_AB44);
        wr(32'h8, 32'h0000_0000, 4'b1111);
        wr(32'hB, 32'h0000_005A, 4'b1000);
        wr(32'h8, 32'h0000_1234, 4'b0011);
        rd(32'h8, rv); chk("ram_sb_sh_lo", rv, 32'h5A00_1234);
        wr(32'hFFC, 32'hCAFE_F00D, 4'b1111);
        rd(32'hFFC, rv); chk("ram_top_word", rv, 32'hCAFE_F00D);
        wr(32'h0, 32'h0000_0000, 4'b1111);
        wr(32'h1000, 32'hDEAD_BEEF, 4'b1111);
        rd(32'h0, rv); chk("ram_no_alias", rv, 32'h0);
        rd(32'h1000, rv); chk("past_ram_reads0", rv, 32'h0);

        // LED and unmapped
        wr(A_LED, 32'hFFFF_FFFA, 4'b1111);
        chk("leds_write", {28'b0, leds}, 32'hA);
        rd(A_LED, rv); chk("leds_read", rv, 32'h0000_000A);
        rd(32'h8000_0000, rv); chk("unmapped_read", rv, 32'h0);
        wr(32'h8000_0000, 32'hFFFF_FFFF, 4'b1111);
        chk("unmapped_wr_leds", {28'b0, leds}, 32'hA);
        rd(32'h4, rv); chk("unmapped_wr_ram", rv, 32'hBEEF_AB44);
        rd(A_TXD, rv); chk("txdata_reads0", rv, 32'h0);

        // Single UART frame of 0x55
        wr(A_TXD, 32'h0000_0055, 4'b0001);
        chk("push_edge_tx_high", {31'b0, uart_tx}, 32'h1);
        rd(A_STAT, rv); chk("status_after_push", rv, 32'h0000_0100);
        dmem_addr = A_STAT;
        for (int k = 0; k < 45; k++) begin
            cycle();
            txs[k] = uart_tx;
            bsy[k] = dmem_rdata[0];
        end
        chk("tx_falls_next_edge", {31'b0, txs[0]}, 32'h0);
        frame_exp = {1'b1, 8'h55, 1'b0};
        for (int k = 0; k < 10; k++)
            chk($sformatf("frame55_bit%0d", k), {31'b0, txs[4*k+2]}, {31'b0, frame_exp[k]});
        nbusy = 0;
        for (int k = 0; k < 45; k++) if (bsy[k]) nbusy++;
        chk("tx_busy_cycles", nbusy, 40);

        // Burst of 10 writes: write 10 overflows
        txlog.delete();
        logging = 1'b1;
        for (int k = 0; k < 10; k++) wr(A_TXD, 32'h30 + k, 4'b0001);
        rd(A_STAT, rv); chk("status_overflow", rv, 32'h0000_080B);
        wr(A_STAT, 32'hFFFF_FFFF, 4'b1111);
        rd(A_STAT, rv); chk("status_ovf_cleared", rv, 32'h0000_0803);
        // Push into the full FIFO on the very edge the next byte is popped
        n = 0;
        rd(A_STAT, st);
        while (st[0] && n < 200) begin cycle(); rd(A_STAT, st); n++; end
        chk("first_frame_end", {31'b0, st[0]}, 32'h0);
        wr(A_TXD, 32'h39, 4'b0001);
        rd(A_STAT, rv); chk("full_push_with_pop", rv, 32'h0000_0803);
        n = 0;
        rd(A_STAT, st);
        while (st != 32'h4 && n < 1000) begin cycle(); rd(A_STAT, st); n++; end
        chk("drain_status", st, 32'h0000_0004);
        logging = 1'b0;

        frames = 0; i = 0; prev_start = -1;
        while (i + 39 < txlog.size()) begin
            if (txlog[i] == 1'b0) begin
                for (int b = 0; b < 8; b++) byte_rx[b] = txlog[i + 6 + 4*b];
                chk($sformatf("burst_byte%0d", frames), {24'b0, byte_rx}, 32'h30 + frames);
                chk($sformatf("burst_stop%0d", frames), {31'b0, txlog[i + 38]}, 32'h1);
                if (prev_start >= 0)
                    chk($sformatf("burst_gap%0d", frames), i - prev_start, 41);
                prev_start = i;
                frames++;
                i += 40;
            end else begin
                i++;
            end
        end
        chk("burst_frames", frames, 10);

        // Reset during data bit 3
        wr(A_LED, 32'h5, 4'b1111);
        wr(A_TXD, 32'h00, 4'b0001);
        wr(A_TXD, 32'h00, 4'b0001);
        repeat (17) cycle();
        chk("pre_reset_tx_low", {31'b0, uart_tx}, 32'h0);
        rd(A_STAT, rv); chk("pre_reset_status", rv, 32'h0000_0101);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("midframe_rst_tx", {31'b0, uart_tx}, 32'h1);
        rd(A_STAT, rv); chk("midframe_rst_status", rv, 32'h0000_0004);
        chk("midframe_rst_leds", {28'b0, leds}, 32'h0);
        cycle();
        chk("post_rst_stays_idle", {31'b0, uart_tx}, 32'h1);

        // Timer
        wr(A_TMR, 32'h1234_5678, 4'b1111);
        repeat (4) cycle();
        rd(A_TMR, rv);
`ifdef DMEM_TIMER_EN
        chk("timer_after_clear", rv, 32'd4);
`else
        chk("timer_unmapped", rv, 32'd0);
`endif
        repeat (3) cycle();
        rd(A_TMR, rv);
`ifdef DMEM_TIMER_EN
        chk("timer_later", rv, 32'd7);
`else
        chk("timer_unmapped_later", rv, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dmem_mmio_bus.md
Name: dmem_mmio_bus

Overview:
- Data-side bus slave sitting directly downstream of the pipelined CPU's MEM-stage data memory port (dmem_addr/wdata/we/be → dmem_rdata).
- Decodes each access to one of: on-chip data RAM, LED register, UART transmitter (with TX FIFO), or free-running cycle timer.
- Reads are combinational (same cycle), because the CPU captures dmem_rdata into MEM/WB at the end of the MEM cycle. All writes and peripheral state update on clk.

Parameters:
- RAM_WORDS, 1024, data RAM depth in 32-bit words; power of two.
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200).
- FIFO_DEPTH, 8, UART TX FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- dmem_addr  in  32  byte address from CPU MEM stage
- dmem_wdata  in  32  store data, unshifted (rs2 value)
- dmem_we  in  1  store strobe, one cycle per store
- dmem_be  in  4  byte-lane enables
- dmem_rdata  out  32  read data, combinational
- leds  out  4  LED register
- uart_tx  out  1  UART serial output, 8N1, idle high

Behaviour:
- Address map:
  - RAM: addr < RAM_WORDS*4, word index addr[log2(RAM_WORDS)+1:2].
  - LED: 0xFFFF_FFF0.
  - UART TXDATA: 0xFFFF_FFF4.
  - UART STATUS: 0xFFFF_FFF8.
  - TIMER: 0xFFFF_FFFC.
  - Anything else is unmapped: read returns 0, write is ignored.
- Reads:
  - Always return the full aligned word; the CPU does no lane extraction.
  - LED reads as {28'b0, leds}.
  - TXDATA reads 0.
  - STATUS = {16'b0, count[7:0], 4'b0, overflow, fifo_empty, fifo_full, tx_busy}.
- RAM writes, on the clk edge with dmem_we=1:
  - Only lanes with be=1 are written.
  - Lane data by be pattern:
    - single-bit be: every lane takes wdata[7:0];
    - 0011 or 1100: lanes take wdata[15:0];
    - otherwise: wdata as-is.
  - RAM contents are not reset.
- LED write: leds <= wdata[3:0]. Reset value 0.
- TXDATA write pushes wdata[7:0] into the FIFO:
  - If the FIFO is full and no pop occurs that cycle, the byte is dropped and sticky overflow is set to 1.
  - Full plus simultaneous pop: the push is accepted and count is unchanged.
- STATUS write (any data) clears overflow.
- TX FSM states:
  - IDLE (uart_tx=1): at an edge with FIFO non-empty, pop the head into the shift register, clear the bit counter, go to START.
  - START (uart_tx=0): hold CLKS_PER_BIT cycles, then go to DATA.
  - DATA: send bit 0 first, each bit CLKS_PER_BIT cycles, 8 bits, then go to STOP.
  - STOP (uart_tx=1): hold CLKS_PER_BIT cycles, then go to IDLE.
- TX timing:
  - One IDLE cycle always separates frames.
  - uart_tx is a registered output.
  - Frame length is 10*CLKS_PER_BIT cycles.
  - There is no bypass: a byte written while empty/IDLE is pushed at edge N and popped at edge N+1, with uart_tx falling at edge N+1.
- tx_busy = (state != IDLE).
- count ranges 0..FIFO_DEPTH; read/write pointers wrap modulo FIFO_DEPTH.
- Reset values: FIFO empty, count=0, overflow=0, state IDLE, baud counter 0, uart_tx=1, leds=0, timer=0.
  - A reset mid-frame aborts the frame and drives uart_tx=1 on the next edge.

Optional Feature:
- Macro: DMEM_TIMER_EN.
- Defined:
  - 32-bit timer increments every cycle and wraps from 0xFFFF_FFFF to 0.
  - A read of 0xFFFF_FFFC returns the current value.
  - Any write to 0xFFFF_FFFC sets the timer to 0 at that edge; it increments from the next edge.
- Not defined: no timer logic; 0xFFFF_FFFC behaves as unmapped (reads 0, writes ignored).

Test Plan:
- SB 0xAB to addr 0x0000_0005 (be=0010) after SW 0x1122_3344 to 0x4 → reading 0x4 returns 0x1122_AB44. SH 0xBEEF to 0x6 (be=1100) → reads 0xBEEF_AB44.
- CLKS_PER_BIT=4, write 0x55 to 0xFFFF_FFF4 → uart_tx falls one edge after push. Sampled mid-bit: 0,1,0,1,0,1,0,1,0,1 (start, LSB first, stop). tx_busy=1 for 40 cycles.
- CLKS_PER_BIT=4, FIFO_DEPTH=8, 10 back-to-back TXDATA writes while IDLE:
  - write 1 pops at the next edge (same edge as write 2), so writes 2–9 fill the FIFO;
  - write 10 is dropped → STATUS reads 0x0000_080B (count=8, overflow=1, fifo_full=1, tx_busy=1);
  - exactly 9 frames are transmitted; a write to STATUS then clears bit 3.
- Write 0xFFFF_FFFA to 0xFFFF_FFF0 → leds=4'hA. Reading 0xFFFF_FFF0 returns 0x0000_000A. Read of 0x8000_0000 returns 0; write there alters nothing.
- Assert rst for 1 cycle during DATA bit 3 → next edge uart_tx=1, STATUS=0x0000_0004, leds=0.
- With DMEM_TIMER_EN: write 0xFFFF_FFFC, then read 5 cycles later → 4. Without the macro: the same read → 0.
